mux_rr: RTL and testbench

- Parametrised N-channel, WIDTH-bit round-robin multiplexer with a registered output stage and a valid/ready handshake.
- Next generation of the 2:1 alternating data mux, which toggled between two inputs every clock.
- Sits between several narrow data producers and one downstream consumer on the same clock.
- Adds channel count, per-channel valid, downstream backpressure, a per-channel consume strobe, and a mode that skips idle channels.

---
 rtl/mux_rr.sv | 135 +++++++++++++
 tb/tb_mux_rr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// N-channel round-robin mux with a registered output word, valid/ready handshake and one-hot consume strobe.
// Latency: 1 clk from input to output; backpressure: ready_in low with valid_out high freezes output, ptr and acks.
// Optional MUX_RR_PARITY_EN adds parity_out, the XOR reduction of the captured word.
module mux_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int MODE  = 1,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   data_in,
    input  logic [NCH-1:0]         valid_in,
    input  logic                   ready_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic [SELW-1:0]        sel_out,
    output logic [NCH-1:0]         ack_out
`ifdef MUX_RR_PARITY_EN
    ,
    output logic                   parity_out
`endif
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             upd;
    logic             found;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] x);
        if (int'(x) >= NCH - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    assign upd = !valid_q || ready_in;

    // MODE 1 scans upward from ptr with wrap; MODE 0 only looks at the channel under ptr.
    always_comb begin
        found = 1'b0;
        grant = ptr_q;
        if (MODE == 0) begin
            found = valid_in[ptr_q];
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && valid_in[(int'(ptr_q) + i) % NCH]) begin
                    found = 1'b1;
                    grant = SELW'((int'(ptr_q) + i) % NCH);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (SELW'(k) == grant) begin
                grant_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ack_out = '0;
        if (!reset && upd && found) begin
            ack_out[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (upd) begin
            valid_d = found;
            if (found) begin
                data_d = grant_data;
                sel_d  = grant;
            end
            // Strict rotation burns a slot on idle channels; skip mode resumes after the winner.
            if (MODE == 0) begin
                ptr_d = wrap_inc(ptr_q);
            end else if (found) begin
                ptr_d = wrap_inc(grant);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sel_out   = sel_q;

`ifdef MUX_RR_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (upd && found) begin
            parity_d = ^grant_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr: a 3-channel skip-mode instance and a 2-channel strict-rotation instance.
module tb_mux_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: NCH=3, WIDTH=4, MODE=1
    logic [11:0] data_a;
    logic [2:0]  valid_a;
    logic        ready_a;
    logic [3:0]  dout_a;
    logic        vout_a;
    logic [1:0]  sel_a;
    logic [2:0]  ack_a;

    // Instance B: NCH=2, WIDTH=4, MODE=0
    logic [7:0]  data_b;
    logic [1:0]  valid_b;
    logic        ready_b;
    logic [3:0]  dout_b;
    logic        vout_b;
    logic [0:0]  sel_b;
    logic [1:0]  ack_b;

`ifdef MUX_RR_PARITY_EN
    logic par_a;
    logic par_b;
`endif

    mux_rr #(.WIDTH(4), .NCH(3), .MODE(1)) u_rr_a (
        .clk(clk), .reset(reset), .data_in(data_a), .valid_in(valid_a), .ready_in(ready_a),
        .data_out(dout_a), .valid_out(vout_a), .sel_out(sel_a), .ack_out(ack_a)
`ifdef MUX_RR_PARITY_EN
        , .parity_out(par_a)
`endif
    );

    mux_rr #(.WIDTH(4), .NCH(2), .MODE(0)) u_rr_b (
        .clk(clk), .reset(reset), .data_in(data_b), .valid_in(valid_b), .ready_in(ready_b),
        .data_out(dout_b), .valid_out(vout_b), .sel_out(sel_b), .ack_out(ack_b)
`ifdef MUX_RR_PARITY_EN
        , .parity_out(par_b)
`endif
    );

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        data_a  = 12'hCBA;
        valid_a = 3'b111;
        ready_a = 1'b1;
        data_b  = 8'h93;
        valid_b = 2'b00;
        ready_b = 1'b1;
        #1;
        tests++; if (vout_a !== 1'b0)  begin fails++; $display("FAIL reset_vout: got %b expected 0", vout_a); end
        tests++; if (dout_a !== 4'h0)  begin fails++; $display("FAIL reset_dout: got %h expected 0", dout_a); end
        tests++; if (sel_a !== 2'd0)   begin fails++; $display("FAIL reset_sel: got %0d expected 0", sel_a); end
        tests++; if (ack_a !== 3'b000) begin fails++; $display("FAIL reset_ack: got %b expected 000", ack_a); end
`ifdef MUX_RR_PARITY_EN
        tests++; if (par_a !== 1'b0)   begin fails++; $display("FAIL reset_parity: got %b expected 0", par_a); end
`endif
        @(posedge clk); #1;
        tests++; if (vout_a !== 1'b0 || ack_a !== 3'b000) begin
            fails++; $display("FAIL reset_hold: vout %b ack %b expected 0 000", vout_a, ack_a);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (ack_a !== 3'b001) begin fails++; $display("FAIL first_ack: got %b expected 001", ack_a); end
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'hA || sel_a !== 2'd0 || vout_a !== 1'b1) begin
            fails++; $display("FAIL first_grant: dout %h sel %0d vout %b expected A 0 1", dout_a, sel_a, vout_a);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_d [5];
        logic [1:0] exp_s [5];
        exp_d = '{4'hA, 4'hB, 4'hC, 4'hA, 4'hB};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        pulse_reset();
        data_a  = 12'hCBA;
        valid_a = 3'b111;
        ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++; if (ack_a !== (3'b001 << exp_s[i])) begin
                fails++; $display("FAIL rot_ack[%0d]: got %b expected %b", i, ack_a, 3'b001 << exp_s[i]);
            end
            @(posedge clk); #1;
            tests++; if (dout_a !== exp_d[i] || sel_a !== exp_s[i] || vout_a !== 1'b1) begin
                fails++; $display("FAIL rot[%0d]: dout %h sel %0d vout %b expected %h %0d 1",
                                  i, dout_a, sel_a, vout_a, exp_d[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Entering with dout=B, sel=1, vout=1 left by the rotation run.
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (vout_a !== 1'b0 || dout_a !== 4'h0 || sel_a !== 2'd0) begin
            fails++; $display("FAIL midreset_async: vout %b dout %h sel %0d expected 0 0 0", vout_a, dout_a, sel_a);
        end
        tests++; if (ack_a !== 3'b000) begin fails++; $display("FAIL midreset_ack: got %b expected 000", ack_a); end
        @(posedge clk); #1;
        tests++; if (vout_a !== 1'b0 || ack_a !== 3'b000) begin
            fails++; $display("FAIL midreset_hold: vout %b ack %b expected 0 000", vout_a, ack_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'hA || sel_a !== 2'd0) begin
            fails++; $display("FAIL midreset_regrant: dout %h sel %0d expected A 0", dout_a, sel_a);
        end
    endtask

    task automatic test_skip();
        pulse_reset();
        data_a  = 12'hCBA;
        valid_a = 3'b100;
        ready_a = 1'b1;
        #1;
        tests++; if (ack_a !== 3'b100) begin fails++; $display("FAIL skip_ack: got %b expected 100", ack_a); end
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'hC || sel_a !== 2'd2 || vout_a !== 1'b1) begin
            fails++; $display("FAIL skip_grant: dout %h sel %0d vout %b expected C 2 1", dout_a, sel_a, vout_a);
        end
        @(negedge clk);
        valid_a = 3'b000;
        #1;
        tests++; if (ack_a !== 3'b000) begin fails++; $display("FAIL idle_ack: got %b expected 000", ack_a); end
        @(posedge clk); #1;
        tests++; if (vout_a !== 1'b0 || dout_a !== 4'hC || sel_a !== 2'd2) begin
            fails++; $display("FAIL idle_hold: vout %b dout %h sel %0d expected 0 C 2", vout_a, dout_a, sel_a);
        end
        @(negedge clk);
        valid_a = 3'b111;
        #1;
        tests++; if (ack_a !== 3'b001) begin fails++; $display("FAIL skip_wrap_ptr: ack %b expected 001", ack_a); end
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'hA || sel_a !== 2'd0) begin
            fails++; $display("FAIL skip_wrap_grant: dout %h sel %0d expected A 0", dout_a, sel_a);
        end
    endtask

    task automatic test_strict();
        logic       exp_v [4];
        logic [1:0] exp_k [4];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_k = '{2'b00, 2'b10, 2'b00, 2'b10};
        pulse_reset();
        data_b  = 8'h93;
        valid_b = 2'b10;
        ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++; if (ack_b !== exp_k[i]) begin
                fails++; $display("FAIL strict_ack[%0d]: got %b expected %b", i, ack_b, exp_k[i]);
            end
            @(posedge clk); #1;
            tests++; if (vout_b !== exp_v[i]) begin
                fails++; $display("FAIL strict_vout[%0d]: got %b expected %b", i, vout_b, exp_v[i]);
            end
            if (i > 0) begin
                tests++; if (dout_b !== 4'h9 || sel_b !== 1'b1) begin
                    fails++; $display("FAIL strict_word[%0d]: dout %h sel %0d expected 9 1", i, dout_b, sel_b);
                end
            end
        end
        valid_b = 2'b00;
    endtask

    task automatic test_backpressure();
        pulse_reset();
        data_a  = 12'h765;
        valid_a = 3'b111;
        ready_a = 1'b1;
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'h5 || sel_a !== 2'd0 || vout_a !== 1'b1) begin
            fails++; $display("FAIL bp_load: dout %h sel %0d vout %b expected 5 0 1", dout_a, sel_a, vout_a);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ready_a = 1'b0;
            data_a  = 12'hEEE;
            #1;
            tests++; if (ack_a !== 3'b000) begin fails++; $display("FAIL bp_ack[%0d]: got %b expected 000", i, ack_a); end
            @(posedge clk); #1;
            tests++; if (dout_a !== 4'h5 || sel_a !== 2'd0 || vout_a !== 1'b1) begin
                fails++; $display("FAIL bp_hold[%0d]: dout %h sel %0d vout %b expected 5 0 1", i, dout_a, sel_a, vout_a);
            end
        end
        @(negedge clk);
        data_a  = 12'h765;
        ready_a = 1'b1;
        #1;
        tests++; if (ack_a !== 3'b010) begin fails++; $display("FAIL bp_release_ack: got %b expected 010", ack_a); end
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'h6 || sel_a !== 2'd1 || vout_a !== 1'b1) begin
            fails++; $display("FAIL bp_release: dout %h sel %0d vout %b expected 6 1 1", dout_a, sel_a, vout_a);
        end
    endtask

`ifdef MUX_RR_PARITY_EN
    task automatic test_parity();
        pulse_reset();
        data_a  = 12'h037;
        valid_a = 3'b001;
        ready_a = 1'b1;
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'h7 || par_a !== 1'b1) begin
            fails++; $display("FAIL parity_7: dout %h par %b expected 7 1", dout_a, par_a);
        end
        @(negedge clk);
        valid_a = 3'b010;
        @(posedge clk); #1;
        tests++; if (dout_a !== 4'h3 || par_a !== 1'b0) begin
            fails++; $display("FAIL parity_3: dout %h par %b expected 3 0", dout_a, par_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_reset_mid();
        test_skip();
        test_strict();
        test_backpressure();
`ifdef MUX_RR_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
